// File: rtl/r_type_multicycle_core.sv
// Multicycle MIPS-style R-type core: each instruction walks FETCH, DECODE, EXEC, WB.
// Instruction memory is loaded through the imem_* port while the core is not busy.
module r_type_multicycle_core #(
  parameter int  DATA_W     = 32,
  parameter int  IMEM_DEPTH = 16,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              imem_we,
  input  logic [AW-1:0]     imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [AW-1:0]     pc,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_BREAK = 6'd13;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] regs [32];
  logic [31:0]       imem [IMEM_DEPTH];

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              funct_ok;
  logic              shamt_big;

  assign rs_val    = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val    = (rt == 5'd0) ? '0 : regs[rt];
  assign funct_ok  = funct inside {F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
  assign shamt_big = int'(shamt) >= DATA_W;

  // NOTE: alu_res gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    case (funct)
      F_ADD:   alu_res = a_q + b_q;
      F_SUB:   alu_res = a_q - b_q;
      F_AND:   alu_res = a_q & b_q;
      F_OR:    alu_res = a_q | b_q;
      F_NOR:   alu_res = ~(a_q | b_q);
      F_SLT:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
      F_SLL:   alu_res = shamt_big ? '0 : (b_q << shamt);
      F_SRL:   alu_res = shamt_big ? '0 : (b_q >> shamt);
      default: alu_res = '0;
    endcase
  end

  // NOTE: instruction memory has no reset so that rst leaves a loaded program intact.
  always_ff @(posedge clk) begin
    if (imem_we && !busy) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the register file is flop-based and reset to reg[i]=i, which rules out a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      zero     <= 1'b0;
      retired  <= '0;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_out  <= '0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            retired <= '0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q <= rs_val;
          b_q <= rt_val;
          if (opcode != 6'd0 || (!funct_ok && funct != F_BREAK)) begin
            state   <= S_HALT;
            illegal <= 1'b1;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end else if (funct == F_BREAK) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out  <= alu_res;
          zero     <= (alu_res == '0);
          wb_valid <= 1'b1;
          wb_addr  <= rd;
          wb_data  <= alu_res;
          state    <= S_WB;
        end
        S_WB: begin
          if (rd != 5'd0) begin
            regs[rd] <= alu_out;
          end
          pc       <= pc + AW'(1);
          retired  <= retired + 16'd1;
          wb_valid <= 1'b0;
          wb_addr  <= '0;
          wb_data  <= '0;
          state    <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_type_multicycle_core.sv
// Scoreboard bench for r_type_multicycle_core: a 32-bit/16-word core and an 8-bit/4-word core.
// Directed programs push expected write-backs; monitors pop and compare on every wb_valid.
module tb_r_type_multicycle_core;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  pc;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t q  [$];
  exp_t q2 [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, halted, illegal, wb_valid, zero;
  logic [3:0]  pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] retired;

  logic        rst2, start2, imem_we2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic        busy2, halted2, illegal2, wb_valid2, zero2;
  logic [1:0]  pc2;
  logic [4:0]  wb_addr2;
  logic [7:0]  wb_data2;
  logic [15:0] retired2;

  r_type_multicycle_core #(.DATA_W(32), .IMEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .halted(halted), .illegal(illegal), .pc(pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .zero(zero), .retired(retired)
  );

  r_type_multicycle_core #(.DATA_W(8), .IMEM_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .busy(busy2), .halted(halted2), .illegal(illegal2), .pc(pc2),
    .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2), .zero(zero2), .retired(retired2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rt_op(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  task automatic wr(input int d, input int a, input logic [31:0] w);
    @(negedge clk);
    if (d == 0) begin
      imem_we = 1'b1; imem_addr = 4'(a); imem_wdata = w;
    end else begin
      imem_we2 = 1'b1; imem_addr2 = 2'(a); imem_wdata2 = w;
    end
    @(negedge clk);
    imem_we  = 1'b0;
    imem_we2 = 1'b0;
  endtask

  task automatic go(input int d);
    @(negedge clk);
    if (d == 0) start = 1'b1;
    else        start2 = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic expect_wb(input int d, input int addr, input logic [31:0] data, input int p);
    exp_t e;
    e.addr = 5'(addr);
    e.data = data;
    e.pc   = 4'(p);
    if (d == 0) q.push_back(e);
    else        q2.push_back(e);
  endtask

  task automatic wait_halt(input int d, input int maxc);
    int n = 0;
    while (((d == 0) ? !halted : !halted2) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check((d == 0) ? "halt_reached" : "halt_reached_dut2", 32'((d == 0) ? halted : halted2), 32'd1);
  endtask

  // Scoreboard monitors: compare every write-back, and require quiet wb_addr/wb_data otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got addr %0d data 0x%08h expected no write-back", wb_addr, wb_data);
        end else begin
          e = q.pop_front();
          check("wb_addr", 32'(wb_addr), 32'(e.addr));
          check("wb_data", wb_data, e.data);
          check("wb_pc", 32'(pc), 32'(e.pc));
        end
      end else begin
        check("idle_wb_addr", 32'(wb_addr), 32'd0);
        check("idle_wb_data", wb_data, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst2 && wb_valid2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb_dut2: got addr %0d data 0x%02h expected no write-back", wb_addr2, wb_data2);
      end else begin
        e = q2.pop_front();
        check("wb_addr_dut2", 32'(wb_addr2), 32'(e.addr));
        check("wb_data_dut2", 32'(wb_data2), e.data);
        check("wb_pc_dut2", 32'(pc2), 32'(e.pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    rst2 = 1'b1; start2 = 1'b0; imem_we2 = 1'b0; imem_addr2 = '0; imem_wdata2 = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // add $3,$1,$2 then BREAK; write-back lands on the 4th edge counting the start edge.
    wr(0, 0, 32'h00221820);
    wr(0, 1, 32'h0000000D);
    expect_wb(0, 3, 32'd3, 0);
    go(0);
    n = 1;
    while (!wb_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("add_latency", 32'(n), 32'd4);
    wait_halt(0, 20);
    check("add_illegal", 32'(illegal), 32'd0);
    check("add_retired", 32'(retired), 32'd1);
    check("add_pc_at_break", 32'(pc), 32'd1);
    check("add_zero", 32'(zero), 32'd0);

    // sub $4,$2,$2 -> 0; add $7,$4,$0 reads reg4 back.
    wr(0, 0, 32'h00422022);
    wr(0, 1, rt_op(4, 0, 7, 0, 32));
    wr(0, 2, 32'h0000000D);
    expect_wb(0, 4, 32'd0, 0);
    expect_wb(0, 7, 32'd0, 1);
    go(0);
    wait_halt(0, 30);
    check("sub_zero", 32'(zero), 32'd1);
    check("sub_retired", 32'(retired), 32'd2);

    // sub $5,$0,$1 -> -1; slt $6,$5,$1 -> 1 (signed).
    wr(0, 0, 32'h00012822);
    wr(0, 1, 32'h00A1302A);
    wr(0, 2, 32'h0000000D);
    expect_wb(0, 5, 32'hFFFF_FFFF, 0);
    expect_wb(0, 6, 32'd1, 1);
    go(0);
    wait_halt(0, 30);
    check("slt_retired", 32'(retired), 32'd2);
    check("slt_zero", 32'(zero), 32'd0);

    // Remaining ALU ops, wraparound add, rd=0 write suppression; start pulsed while busy.
    wr(0, 0,  rt_op(8, 3, 9, 0, 37));    // or   -> 8|3
    wr(0, 1,  rt_op(5, 12, 10, 0, 36));  // and  -> 0xFFFFFFFF & 12
    wr(0, 2,  rt_op(8, 3, 11, 0, 39));   // nor  -> ~11
    wr(0, 3,  rt_op(0, 3, 12, 4, 0));    // sll  3<<4
    wr(0, 4,  rt_op(0, 5, 13, 28, 2));   // srl  0xFFFFFFFF>>28
    wr(0, 5,  rt_op(0, 5, 14, 31, 0));   // sll  0xFFFFFFFF<<31
    wr(0, 6,  rt_op(5, 6, 15, 0, 32));   // add  -1+1 wraps to 0
    wr(0, 7,  rt_op(6, 5, 16, 0, 42));   // slt  1 < -1 is false
    wr(0, 8,  rt_op(1, 2, 0, 0, 32));    // add  into r0
    wr(0, 9,  rt_op(0, 0, 17, 0, 37));   // or   r0|r0
    wr(0, 10, 32'h0000000D);
    expect_wb(0, 9,  32'h0000_000B, 0);
    expect_wb(0, 10, 32'h0000_000C, 1);
    expect_wb(0, 11, 32'hFFFF_FFF4, 2);
    expect_wb(0, 12, 32'h0000_0030, 3);
    expect_wb(0, 13, 32'h0000_000F, 4);
    expect_wb(0, 14, 32'h8000_0000, 5);
    expect_wb(0, 15, 32'h0000_0000, 6);
    expect_wb(0, 16, 32'h0000_0000, 7);
    expect_wb(0, 0,  32'h0000_0003, 8);
    expect_wb(0, 17, 32'h0000_0000, 9);
    go(0);
    repeat (2) @(posedge clk);
    go(0);
    wait_halt(0, 100);
    check("alu_retired", 32'(retired), 32'd10);
    check("alu_pc_at_break", 32'(pc), 32'd10);
    check("alu_zero", 32'(zero), 32'd1);
    check("alu_illegal", 32'(illegal), 32'd0);

    // Non-zero opcode halts as illegal; restart clears illegal; unsupported funct is illegal too.
    wr(0, 0, 32'h20000000);
    go(0);
    wait_halt(0, 20);
    check("opc_illegal", 32'(illegal), 32'd1);
    check("opc_retired", 32'(retired), 32'd0);
    check("opc_pc", 32'(pc), 32'd0);
    go(0);
    check("restart_illegal_clear", 32'(illegal), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_halted", 32'(halted), 32'd0);
    wait_halt(0, 20);
    check("opc_illegal_again", 32'(illegal), 32'd1);
    wr(0, 0, rt_op(1, 2, 3, 0, 3));
    go(0);
    wait_halt(0, 20);
    check("funct_illegal", 32'(illegal), 32'd1);
    check("funct_retired", 32'(retired), 32'd0);

    // Reset in EXEC of the second add; imem write during busy must be dropped.
    wr(0, 0, rt_op(3, 3, 3, 0, 32));
    wr(0, 1, rt_op(3, 3, 3, 0, 32));
    wr(0, 2, 32'h0000000D);
    expect_wb(0, 3, 32'd6, 0);
    go(0);
    wr(0, 0, 32'h0000000D);
    n = 0;
    while (!wb_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_rst_wb_seen", 32'(wb_valid), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_wb(0, 3, 32'd6, 0);
    expect_wb(0, 3, 32'd12, 1);
    go(0);
    wait_halt(0, 30);
    check("postrst_retired", 32'(retired), 32'd2);
    check("postrst_pc", 32'(pc), 32'd2);

    // Small core: four nops wrap pc 3->0; then r0 reads zero and 8-bit subtraction wraps.
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) wr(1, i, 32'h0000_0000);
    for (int i = 0; i < 5; i++) expect_wb(1, 0, 32'd0, i % 4);
    go(1);
    n = 0;
    while (retired2 != 16'd5 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("nop_retired_dut2", 32'(retired2), 32'd5);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    wr(1, 0, rt_op(0, 0, 9, 0, 37));
    wr(1, 1, rt_op(0, 1, 10, 0, 34));
    wr(1, 2, 32'h0000000D);
    expect_wb(1, 9,  32'h0000_0000, 0);
    expect_wb(1, 10, 32'h0000_00FF, 1);
    go(1);
    wait_halt(1, 30);
    check("dut2_retired", 32'(retired2), 32'd2);
    check("dut2_illegal", 32'(illegal2), 32'd0);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(q.size()), 32'd0);
    check("sb_empty_dut2", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
